// File: rtl/spi_tx_pkg.sv
// Shared types for the multi-lane SPI transmitter.
//   state_t : transmitter FSM states
//   lane_t  : one lane's transfer word at the default lane width
package spi_tx_pkg;

  localparam int unsigned LANE_WIDTH = 8;

  typedef logic [LANE_WIDTH-1:0] lane_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_GAP,
    ST_FINISH
  } state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_lane_shifter.sv
// One MOSI lane: parallel load, shift left, MSB presented as the serial bit.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture data
//   shift    : move next bit into MSB position
//   data     : parallel word
//   msb      : current serial bit
module spi_lane_shifter
  import spi_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= data;
    end else if (shift) begin
      sreg <= sreg << 1;
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/spi_multi_tx.sv
// Multi-lane SPI transmitter (mode 0) with shared SCK and CS_n.
// Serialises one word per lane MSB-first on data commands, and holds CS_n
// high for a column gap or an image latch period on boundary commands.
//   I_clk, I_rst     : clock, asynchronous active-high reset
//   I_next_data      : send I_data_in (one word per lane)
//   I_next_column    : column boundary (CS_n high for GAP_CYCLES)
//   I_next_image     : image boundary (CS_n high for LATCH_CYCLES)
//   I_data_in        : per-lane words, sampled on accept
//   O_tx_finish      : one-cycle completion pulse
//   O_busy           : command in progress (through the finish cycle)
//   O_overrun        : one-cycle pulse, a command was dropped
//   O_sck, O_cs_n    : shared SPI clock and chip select
//   O_mosi           : per-lane serial data
module spi_multi_tx
  import spi_tx_pkg::*;
#(
  parameter int unsigned SPI_CHANNEL_NUMBER = 4,
  parameter int unsigned BLOCK_DATA_WIDTH_B = 8,
  parameter int unsigned HALF_PERIOD        = 2,
  parameter int unsigned CS_SETUP_CYCLES    = 2,
  parameter int unsigned GAP_CYCLES         = 16,
  parameter int unsigned LATCH_CYCLES       = 256
) (
  input  logic                                                 I_clk,
  input  logic                                                 I_rst,
  input  logic                                                 I_next_data,
  input  logic                                                 I_next_column,
  input  logic                                                 I_next_image,
  input  logic [SPI_CHANNEL_NUMBER-1:0][BLOCK_DATA_WIDTH_B-1:0] I_data_in,
  output logic                                                 O_tx_finish,
  output logic                                                 O_busy,
  output logic                                                 O_overrun,
  output logic                                                 O_sck,
  output logic                                                 O_cs_n,
  output logic [SPI_CHANNEL_NUMBER-1:0]                        O_mosi
);

  localparam int unsigned TMAX =
    max2(max2(HALF_PERIOD, CS_SETUP_CYCLES), max2(GAP_CYCLES, LATCH_CYCLES));
  localparam int unsigned TW = $clog2(TMAX + 1);
  localparam int unsigned BW = $clog2(BLOCK_DATA_WIDTH_B + 1);

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [BW-1:0]   bit_cnt, bit_cnt_n;
  logic            cs_n_q, cs_n_n;
  logic            ovr_q, ovr_n;
  logic            load, shift;
  logic [SPI_CHANNEL_NUMBER-1:0] lane_msb;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      cs_n_q  <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_cnt <= bit_cnt_n;
      cs_n_q  <= cs_n_n;
      ovr_q   <= ovr_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    cs_n_n    = cs_n_q;
    ovr_n     = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;

    case (state)
      ST_IDLE: begin
        // Image beats column beats data; losers of the same cycle are dropped.
        if (I_next_image) begin
          state_n = ST_GAP;
          timer_n = TW'(LATCH_CYCLES);
          cs_n_n  = 1'b1;
          ovr_n   = I_next_column | I_next_data;
        end else if (I_next_column) begin
          state_n = ST_GAP;
          timer_n = TW'(GAP_CYCLES);
          cs_n_n  = 1'b1;
          ovr_n   = I_next_data;
        end else if (I_next_data) begin
          load      = 1'b1;
          bit_cnt_n = BW'(BLOCK_DATA_WIDTH_B);
          cs_n_n    = 1'b0;
          if (cs_n_q) begin
            state_n = ST_CS_SETUP;
            timer_n = TW'(CS_SETUP_CYCLES);
          end else begin
            state_n = ST_BIT_LOW;
            timer_n = TW'(HALF_PERIOD);
          end
        end
      end
      ST_CS_SETUP: begin
        if (timer == TW'(1)) begin
          state_n = ST_BIT_LOW;
          timer_n = TW'(HALF_PERIOD);
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_BIT_LOW: begin
        if (timer == TW'(1)) begin
          state_n = ST_BIT_HIGH;
          timer_n = TW'(HALF_PERIOD);
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_BIT_HIGH: begin
        if (timer == TW'(1)) begin
          // Shift only on leaving SCK high so MOSI is stable for the whole low phase.
          shift     = 1'b1;
          bit_cnt_n = bit_cnt - BW'(1);
          if (bit_cnt == BW'(1)) begin
            state_n = ST_FINISH;
            timer_n = '0;
          end else begin
            state_n = ST_BIT_LOW;
            timer_n = TW'(HALF_PERIOD);
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_GAP: begin
        if (timer == TW'(1)) begin
          state_n = ST_FINISH;
          timer_n = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_FINISH: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (state != ST_IDLE && (I_next_data || I_next_column || I_next_image)) begin
      ovr_n = 1'b1;
    end
  end

  for (genvar g = 0; g < SPI_CHANNEL_NUMBER; g++) begin : g_lane
    spi_lane_shifter #(.WIDTH(BLOCK_DATA_WIDTH_B)) u_shifter (
      .clk   (I_clk),
      .rst   (I_rst),
      .load  (load),
      .shift (shift),
      .data  (I_data_in[g]),
      .msb   (lane_msb[g])
    );
  end

  logic bit_phase;
  assign bit_phase   = (state == ST_BIT_LOW) || (state == ST_BIT_HIGH);
  assign O_sck       = (state == ST_BIT_HIGH);
  assign O_mosi      = bit_phase ? lane_msb : '0;
  assign O_tx_finish = (state == ST_FINISH);
  assign O_busy      = (state != ST_IDLE);
  assign O_overrun   = ovr_q;
  assign O_cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_multi_tx.sv
module tb_spi_multi_tx;

  localparam int LIMIT = 400;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            next_data = 1'b0, next_column = 1'b0, next_image = 1'b0;
  logic [3:0][7:0] data_in = '0;
  logic            tx_finish, busy, overrun, sck, cs_n;
  logic [3:0]      mosi;

  logic            b_next_data = 1'b0, b_next_column = 1'b0, b_next_image = 1'b0;
  logic [0:0][7:0] b_data = '0;
  logic            b_finish, b_busy, b_overrun, b_sck, b_cs_n;
  logic [0:0]      b_mosi;

  always #5 clk = ~clk;

  spi_multi_tx #(
    .SPI_CHANNEL_NUMBER(4), .BLOCK_DATA_WIDTH_B(8), .HALF_PERIOD(2),
    .CS_SETUP_CYCLES(2), .GAP_CYCLES(16), .LATCH_CYCLES(256)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_next_data(next_data), .I_next_column(next_column),
    .I_next_image(next_image), .I_data_in(data_in), .O_tx_finish(tx_finish),
    .O_busy(busy), .O_overrun(overrun), .O_sck(sck), .O_cs_n(cs_n), .O_mosi(mosi)
  );

  spi_multi_tx #(
    .SPI_CHANNEL_NUMBER(1), .BLOCK_DATA_WIDTH_B(8), .HALF_PERIOD(1),
    .CS_SETUP_CYCLES(2), .GAP_CYCLES(16), .LATCH_CYCLES(256)
  ) dut_b (
    .I_clk(clk), .I_rst(rst), .I_next_data(b_next_data), .I_next_column(b_next_column),
    .I_next_image(b_next_image), .I_data_in(b_data), .O_tx_finish(b_finish),
    .O_busy(b_busy), .O_overrun(b_overrun), .O_sck(b_sck), .O_cs_n(b_cs_n), .O_mosi(b_mosi)
  );

  typedef struct {
    logic [2:0]      kind;      // {image, column, data}
    logic [3:0][7:0] data;
    int              inj_cyc;   // 0 = no injected pulse
    logic [2:0]      inj_kind;
    int              exp_fin;
    int              exp_sck1;  // cycle of first SCK rise, 0 = none
    int              exp_csh;   // cycles with CS_n high in 1..finish
    int              exp_ovr;
    int              exp_mnz;   // MOSI ever nonzero
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [3:0][7:0] sb[$];
  vec_t vec[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int fin, first, csh, ovr, busy_bad, bits;
    logic mnz, prev;
    logic [3:0][7:0] got, expb;
    fin = -1; first = 0; csh = 0; ovr = 0; busy_bad = 0; bits = 0;
    mnz = 1'b0; prev = 1'b0; got = '0;
    if (v.kind == 3'b001) sb.push_back(v.data);
    {next_image, next_column, next_data} = v.kind;
    data_in = v.data;
    @(negedge clk);
    {next_image, next_column, next_data} = 3'b000;
    for (int n = 1; n <= LIMIT; n++) begin
      if (n > 1) @(negedge clk);
      if (v.inj_cyc != 0 && n == v.inj_cyc + 1) begin
        {next_image, next_column, next_data} = 3'b000;
      end
      if (!busy) busy_bad++;
      if (cs_n) csh++;
      if (mosi != 4'b0) mnz = 1'b1;
      if (overrun) ovr++;
      if (sck && !prev) begin
        if (first == 0) first = n;
        for (int l = 0; l < 4; l++) got[l] = {got[l][6:0], mosi[l]};
        bits++;
        if (bits == 8) begin
          bits = 0;
          if (sb.size() == 0) begin
            check({tag, "_extra_byte"}, 1, 0);
          end else begin
            expb = sb.pop_front();
            for (int l = 0; l < 4; l++)
              check($sformatf("%s_lane%0d_byte", tag, l), int'(got[l]), int'(expb[l]));
          end
        end
      end
      prev = sck;
      if (tx_finish) begin
        fin = n;
        break;
      end
      if (v.inj_cyc == n) begin
        {next_image, next_column, next_data} = v.inj_kind;
        data_in = 32'h11223344;
      end
    end
    {next_image, next_column, next_data} = 3'b000;
    check({tag, "_finish_cycle"}, fin, v.exp_fin);
    check({tag, "_first_sck_rise"}, first, v.exp_sck1);
    check({tag, "_cs_high_cycles"}, csh, v.exp_csh);
    check({tag, "_overrun_pulses"}, ovr, v.exp_ovr);
    check({tag, "_mosi_nonzero"}, int'(mnz), v.exp_mnz);
    check({tag, "_busy_gaps"}, busy_bad, 0);
    check({tag, "_sb_pending"}, sb.size(), 0);
    @(negedge clk);
    check({tag, "_post_finish"}, int'(tx_finish), 0);
    check({tag, "_post_busy"}, int'(busy), 0);
  endtask

  initial begin
    int fin, hi, lo, first;
    logic prev;
    logic [7:0] bbyte;
    vec_t post;

    vec[0] = '{3'b001, {8'hA5, 8'h3C, 8'hFF, 8'h00}, 0,  3'b000, 35,  5, 0,   0, 1};
    vec[1] = '{3'b001, {8'h01, 8'h80, 8'h55, 8'hAA}, 0,  3'b000, 33,  3, 0,   0, 1};
    vec[2] = '{3'b001, {8'h5A, 8'hC3, 8'h0F, 8'hF0}, 10, 3'b001, 33,  3, 0,   1, 1};
    vec[3] = '{3'b010, {8'h00, 8'h00, 8'h00, 8'h00}, 0,  3'b000, 17,  0, 17,  0, 0};
    vec[4] = '{3'b101, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0,  3'b000, 257, 0, 257, 1, 0};
    vec[5] = '{3'b001, {8'h81, 8'h7E, 8'h00, 8'hFF}, 0,  3'b000, 35,  5, 0,   0, 1};
    vec[6] = '{3'b010, {8'h00, 8'h00, 8'h00, 8'h00}, 5,  3'b010, 17,  0, 17,  1, 0};

    repeat (3) @(negedge clk);
    check("reset_sck", int'(sck), 0);
    check("reset_cs_n", int'(cs_n), 1);
    check("reset_mosi", int'(mosi), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_finish", int'(tx_finish), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vec[i], $sformatf("v%0d", i));

    // Reset in the middle of bit 4 (CS setup applies: bit 4 high at cycles 21-22).
    next_data = 1'b1;
    data_in = '1;
    @(negedge clk);
    next_data = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_sck", int'(sck), 1);
    check("pre_rst_mosi", int'(mosi), 15);
    #2 rst = 1'b1;
    #1;
    check("rst_sck", int'(sck), 0);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_mosi", int'(mosi), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_finish", int'(tx_finish), 0);
    repeat (3) @(negedge clk);
    check("rst_hold_finish", int'(tx_finish), 0);
    rst = 1'b0;
    post = '{3'b001, {8'h3C, 8'hA5, 8'h96, 8'h01}, 0, 3'b000, 35, 5, 0, 0, 1};
    run_vec(post, "post_rst");

    // Single lane, HALF_PERIOD=1.
    fin = -1; hi = 0; lo = 0; first = 0; prev = 1'b0; bbyte = '0;
    b_next_data = 1'b1;
    b_data = 8'hC3;
    @(negedge clk);
    b_next_data = 1'b0;
    for (int n = 1; n <= LIMIT; n++) begin
      if (n > 1) @(negedge clk);
      if (b_sck) hi++;
      else if (n >= 3 && !b_finish) lo++;
      if (b_sck && !prev) begin
        if (first == 0) first = n;
        bbyte = {bbyte[6:0], b_mosi[0]};
      end
      prev = b_sck;
      if (b_finish) begin
        fin = n;
        break;
      end
    end
    check("hp1_finish_cycle", fin, 19);
    check("hp1_first_rise", first, 4);
    check("hp1_sck_high", hi, 8);
    check("hp1_sck_low", lo, 8);
    check("hp1_byte", int'(bbyte), 8'hC3);
    check("hp1_cs_low", int'(b_cs_n), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
